// File: rtl/eth_pkg.sv
// Shared Ethernet bridge definitions: byte type, frame limits and RX FSM state encoding.
package eth_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned ETH_MIN_LEN = 64;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_RECV  = 3'd1;
    localparam logic [2:0] RX_DROP  = 3'd2;
    localparam logic [2:0] RX_LOAD  = 3'd3;
    localparam logic [2:0] RX_DRAIN = 3'd4;

endpackage

// File: rtl/frame_ram.sv
// Frame buffer: 2**ADDR_W bytes, one synchronous write port and one asynchronous read port.
module frame_ram
    import eth_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  byte_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output byte_t             rdata
);

    byte_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_control.sv
// RX frame buffer: stores one MAC frame, filters runt/oversize/errored frames and
// replays good frames downstream on a valid/ready byte stream.
module rx_control
    import eth_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MIN_LEN = ETH_MIN_LEN,
    parameter int unsigned MAX_LEN = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    input  logic        rx_last_byte,
    input  logic        rx_error,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] frm_len,
    output logic [15:0] drop_cnt,
    output logic        busy
);

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] frm_len_q, frm_len_d;
    logic [15:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    byte_t       out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        mid_frame_q, mid_frame_d;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    byte_t             rdata;
    logic [15:0]       total;
    logic [15:0]       rd_next;
    logic              last_beat;
    logic              hs;
    logic              count_drop;

    assign total     = len_q + 16'd1;
    assign rd_next   = rd_ptr_q + 16'd1;
    assign last_beat = rx_data_valid & rx_last_byte;
    assign hs        = out_valid_q & out_ready;

    frame_ram #(
        .ADDR_W (ADDR_W)
    ) u_frame_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (rx_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        frm_len_d   = frm_len_q;
        rd_ptr_d    = rd_ptr_q;
        drop_cnt_d  = drop_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        mid_frame_d = mid_frame_q;
        we          = 1'b0;
        waddr       = len_q[ADDR_W-1:0];
        raddr       = rd_next[ADDR_W-1:0];
        count_drop  = 1'b0;

        if (rx_data_valid) begin
            mid_frame_d = ~rx_last_byte;
        end

        case (state_q)
            RX_IDLE: begin
                if (rx_data_valid) begin
                    we    = 1'b1;
                    waddr = '0;
                    len_d = 16'd1;
                    if (rx_last_byte) begin
                        count_drop = 1'b1;
                    end else begin
                        state_d = RX_RECV;
                    end
                end
            end
            RX_RECV: begin
                if (rx_data_valid) begin
                    if (len_q == 16'(MAX_LEN)) begin
                        if (rx_last_byte) begin
                            count_drop = 1'b1;
                            state_d    = RX_IDLE;
                        end else begin
                            state_d = RX_DROP;
                        end
                    end else begin
                        we    = 1'b1;
                        len_d = total;
                        if (rx_last_byte) begin
                            if (total < 16'(MIN_LEN) || rx_error) begin
                                count_drop = 1'b1;
                                state_d    = RX_IDLE;
                            end else begin
                                frm_len_d = total;
                                state_d   = RX_LOAD;
                            end
                        end
                    end
                end
            end
            RX_DROP: begin
                if (last_beat) begin
                    count_drop = 1'b1;
                    state_d    = RX_IDLE;
                end
            end
            RX_LOAD: begin
                count_drop  = last_beat;
                raddr       = '0;
                out_data_d  = rdata;
                rd_ptr_d    = '0;
                out_valid_d = 1'b1;
                out_last_d  = (frm_len_q == 16'd1);
                state_d     = RX_DRAIN;
            end
            RX_DRAIN: begin
                count_drop = last_beat;
                if (hs) begin
                    if (!out_last_q) begin
                        rd_ptr_d   = rd_next;
                        out_data_d = rdata;
                        out_last_d = (rd_ptr_q + 16'd2 == frm_len_q);
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        // A frame still arriving from the MAC must be skipped, not buffered mid-way.
                        state_d     = mid_frame_d ? RX_DROP : RX_IDLE;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (count_drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RX_IDLE;
            len_q       <= '0;
            frm_len_q   <= '0;
            rd_ptr_q    <= '0;
            drop_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            mid_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            frm_len_q   <= frm_len_d;
            rd_ptr_q    <= rd_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            mid_frame_q <= mid_frame_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frm_len   = frm_len_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (state_q != RX_IDLE);

endmodule
